// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers,
// bus multiplexer and 64-bit result ALU, sequenced by external strobes.
module cpu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             R0in,  R1in,  R2in,  R3in,
  input  logic             R4in,  R5in,  R6in,  R7in,
  input  logic             R8in,  R9in,  R10in, R11in,
  input  logic             R12in, R13in, R14in, R15in,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             Zin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             Yin,
  input  logic             Cin,
  input  logic             InPortin,
  input  logic             R0out,  R1out,  R2out,  R3out,
  input  logic             R4out,  R5out,  R6out,  R7out,
  input  logic             R8out,  R9out,  R10out, R11out,
  input  logic             R12out, R13out, R14out, R15out,
  input  logic             PCout,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             ZHighOut,
  input  logic             ZLowOut,
  input  logic             MDRout,
  input  logic             Cout,
  input  logic             InPortOut,
  input  logic             incPC,
  input  logic             Read,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] BusMuxOut
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [15:0] rin;
  logic [15:0] rout;

  assign rin  = {R15in, R14in, R13in, R12in,
                 R11in, R10in, R9in,  R8in,
                 R7in,  R6in,  R5in,  R4in,
                 R3in,  R2in,  R1in,  R0in};
  assign rout = {R15out, R14out, R13out, R12out,
                 R11out, R10out, R9out,  R8out,
                 R7out,  R6out,  R5out,  R4out,
                 R3out,  R2out,  R1out,  R0out};

  logic [WIDTH-1:0]   r_q [16];
  logic [WIDTH-1:0]   r_d [16];
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   ir_q, ir_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mar_q, mar_d;
  logic [WIDTH-1:0]   mdr_q, mdr_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [WIDTH-1:0]   inport_q, inport_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu;

  // Bus mux: later assignments win, so R0 has the highest priority
  always_comb begin
    bus = '0;
    if (Cout)      bus = c_q;
    if (InPortOut) bus = inport_q;
    if (MDRout)    bus = mdr_q;
    if (PCout)     bus = pc_q;
    if (ZLowOut)   bus = z_q[WIDTH-1:0];
    if (ZHighOut)  bus = z_q[2*WIDTH-1:WIDTH];
    if (LOout)     bus = lo_q;
    if (HIout)     bus = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (rout[i]) bus = r_q[i];
    end
  end

  assign BusMuxOut = bus;

  logic signed [WIDTH-1:0]   sa, sb;
  logic signed [2*WIDTH-1:0] ax, bx;
  logic [2*WIDTH-1:0]        dbl;
  logic [2*WIDTH-1:0]        rr, rl;
  logic [SW-1:0]             sh;
  logic [WIDTH-1:0]          quo, rem;
  logic [WIDTH-1:0]          lo_r;

  assign sa  = y_q;
  assign sb  = bus;
  assign ax  = {{WIDTH{y_q[WIDTH-1]}}, y_q};
  assign bx  = {{WIDTH{bus[WIDTH-1]}}, bus};
  assign sh  = bus[SW-1:0];
  assign dbl = {y_q, y_q};
  assign rr  = dbl >> sh;
  assign rl  = dbl << sh;

  // Signed divide; zero divisor and MIN/-1 overflow handled explicitly
  always_comb begin
    quo = '0;
    rem = '0;
    if (bus == '0) begin
      rem = y_q;
    end else if (y_q == MIN_INT && bus == '1) begin
      quo = y_q;
    end else begin
      quo = sa / sb;
      rem = sa % sb;
    end
  end

  // ALU: incPC overrides the opcode with B+1
  always_comb begin
    lo_r = '0;
    alu  = '0;
    if (incPC) begin
      alu = {{WIDTH{1'b0}}, bus + WIDTH'(1)};
    end else begin
      case (opcode)
        OP_ADD:  lo_r = y_q + bus;
        OP_SUB:  lo_r = y_q - bus;
        OP_SHR:  lo_r = y_q >> sh;
        OP_SHRA: lo_r = sa >>> sh;
        OP_SHL:  lo_r = y_q << sh;
        OP_ROR:  lo_r = rr[WIDTH-1:0];
        OP_ROL:  lo_r = rl[2*WIDTH-1:WIDTH];
        OP_AND:  lo_r = y_q & bus;
        OP_OR:   lo_r = y_q | bus;
        OP_NEG:  lo_r = -bus;
        OP_NOT:  lo_r = ~bus;
        default: lo_r = '0;
      endcase
      case (opcode)
        OP_MUL:  alu = ax * bx;
        OP_DIV:  alu = {rem, quo};
        default: alu = {{WIDTH{1'b0}}, lo_r};
      endcase
    end
  end

  // Next-state: each register loads on its strobe, else holds
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      r_d[i] = rin[i] ? bus : r_q[i];
    end
    pc_d     = PCin  ? bus : pc_q;
    ir_d     = IRin  ? bus : ir_q;
    hi_d     = HIin  ? bus : hi_q;
    lo_d     = LOin  ? bus : lo_q;
    mar_d    = MARin ? bus : mar_q;
    y_d      = Yin   ? bus : y_q;
    c_d      = Cin   ? bus : c_q;
    mdr_d    = MDRin ? (Read ? Mdatain : bus) : mdr_q;
    inport_d = InPortin ? Mdatain : inport_q;
    z_d      = Zin ? alu : z_q;
  end

  // State registers, cleared asynchronously by clr
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      y_q      <= '0;
      c_q      <= '0;
      inport_q <= '0;
      z_q      <= '0;
    end else begin
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      y_q      <= y_d;
      c_q      <= c_d;
      inport_q <= inport_d;
      z_q      <= z_d;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Scenario bench for cpu_datapath: expected bus values are queued at
// stimulus time and popped when the matching source is driven.
module tb_cpu_datapath;

  logic        clk;
  logic        clr;
  logic [15:0] rin, rout;
  logic PCin, IRin, HIin, LOin, Zin, MARin, MDRin, Yin, Cin, InPortin;
  logic PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, Cout, InPortOut;
  logic        incPC, Read;
  logic [4:0]  opcode;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut;

  logic [31:0] exp_q [$];
  logic [31:0] e;
  int          checks = 0;
  int          passes = 0;

  cpu_datapath #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin), .Zin(Zin),
    .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Cin(Cin),
    .InPortin(InPortin),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),
    .R3out(rout[3]),   .R4out(rout[4]),   .R5out(rout[5]),
    .R6out(rout[6]),   .R7out(rout[7]),   .R8out(rout[8]),
    .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]),
    .R15out(rout[15]),
    .PCout(PCout), .HIout(HIout), .LOout(LOout),
    .ZHighOut(ZHighOut), .ZLowOut(ZLowOut), .MDRout(MDRout),
    .Cout(Cout), .InPortOut(InPortOut),
    .incPC(incPC), .Read(Read), .opcode(opcode),
    .Mdatain(Mdatain), .BusMuxOut(BusMuxOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rin = '0; rout = '0;
    PCin = 0; IRin = 0; HIin = 0; LOin = 0; Zin = 0;
    MARin = 0; MDRin = 0; Yin = 0; Cin = 0; InPortin = 0;
    PCout = 0; HIout = 0; LOout = 0; ZHighOut = 0; ZLowOut = 0;
    MDRout = 0; Cout = 0; InPortOut = 0;
    incPC = 0; Read = 0; opcode = '0; Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  task automatic load_reg(input int k, input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; rin[k] = 1;
    tick();
  endtask

  task automatic load_y(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; Yin = 1;
    tick();
  endtask

  task automatic run_alu(input logic [4:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
    load_y(a);
    load_mdr(b);
    MDRout = 1; opcode = op; Zin = 1;
    tick();
  endtask

  task automatic test_reset();
    clr = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 6; s++) begin
      exp_q.push_back(32'h0);
      rout[0]  = (s == 0);
      PCout    = (s == 1);
      MDRout   = (s == 2);
      ZLowOut  = (s == 3);
      ZHighOut = (s == 4);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (BusMuxOut !== e)
        $display("FAIL reset_src%0d got %h want %h", s, BusMuxOut, e);
      else passes++;
      idle();
    end
    clr = 1;
    tick();
  endtask

  task automatic test_pc_inc();
    PCout = 1; incPC = 1; Zin = 1; MARin = 1;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    tick();
    ZLowOut = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL pc_inc_zlo got %h want %h", BusMuxOut, e);
    else passes++;
    e = exp_q.pop_front();
    checks++;
    if (dut.mar_q !== e)
      $display("FAIL pc_inc_mar got %h want %h", dut.mar_q, e);
    else passes++;
    PCin = 1;
    exp_q.push_back(32'h1);
    tick();
    PCout = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL pc_inc_pc got %h want %h", BusMuxOut, e);
    else passes++;
    idle();
  endtask

  task automatic test_mdr();
    exp_q.push_back(32'd10);
    load_mdr(32'd10);
    MDRout = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL mdr_read got %h want %h", BusMuxOut, e);
    else passes++;
    idle();
    load_reg(1, 32'd7);
    rout[1] = 1; MDRin = 1; Read = 0; Mdatain = 32'd99;
    exp_q.push_back(32'd7);
    tick();
    MDRout = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL mdr_bus got %h want %h", BusMuxOut, e);
    else passes++;
    idle();
    Mdatain = 32'hCAFE_0001; InPortin = 1;
    exp_q.push_back(32'hCAFE_0001);
    tick();
    InPortOut = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL inport got %h want %h", BusMuxOut, e);
    else passes++;
    idle();
  endtask

  task automatic test_and();
    logic [31:0] av [2];
    logic [31:0] bv [2];
    logic [31:0] rv [2];
    av[0] = 32'h2;  bv[0] = 32'h2;  rv[0] = 32'h2;
    av[1] = 32'hF0; bv[1] = 32'h3C; rv[1] = 32'h30;
    for (int i = 0; i < 2; i++) begin
      load_reg(2, av[i]);
      load_reg(3, bv[i]);
      rout[2] = 1; Yin = 1;
      tick();
      rout[3] = 1; opcode = 5'b01010; Zin = 1;
      exp_q.push_back(rv[i]);
      tick();
      ZLowOut = 1; rin[1] = 1;
      tick();
      rout[1] = 1; #1;
      e = exp_q.pop_front();
      checks++;
      if (BusMuxOut !== e)
        $display("FAIL and%0d got %h want %h", i, BusMuxOut, e);
      else passes++;
      idle();
    end
  endtask

  task automatic test_div();
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] qv [4];
    logic [31:0] rv [4];
    av[0] = 32'd16;          bv[0] = 32'hFFFF_FFFE;
    qv[0] = 32'hFFFF_FFF8;   rv[0] = 32'd0;
    av[1] = 32'd17;          bv[1] = 32'd5;
    qv[1] = 32'd3;           rv[1] = 32'd2;
    av[2] = 32'd17;          bv[2] = 32'd0;
    qv[2] = 32'd0;           rv[2] = 32'd17;
    av[3] = 32'hFFFF_FFEF;   bv[3] = 32'd5;
    qv[3] = 32'hFFFF_FFFD;   rv[3] = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(qv[i]);
      exp_q.push_back(rv[i]);
      run_alu(5'b01111, av[i], bv[i]);
      ZLowOut = 1; #1;
      e = exp_q.pop_front();
      checks++;
      if (BusMuxOut !== e)
        $display("FAIL div%0d_lo got %h want %h", i, BusMuxOut, e);
      else passes++;
      ZLowOut = 0; ZHighOut = 1; #1;
      e = exp_q.pop_front();
      checks++;
      if (BusMuxOut !== e)
        $display("FAIL div%0d_hi got %h want %h", i, BusMuxOut, e);
      else passes++;
      idle();
    end
  endtask

  task automatic test_mul();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFF_FFFF);
    run_alu(5'b01110, 32'h8000_0000, 32'd2);
    ZLowOut = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL mul_lo got %h want %h", BusMuxOut, e);
    else passes++;
    ZLowOut = 0; ZHighOut = 1; HIin = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL mul_hi got %h want %h", BusMuxOut, e);
    else passes++;
    exp_q.push_back(32'hFFFF_FFFF);
    tick();
    HIout = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL mul_hireg got %h want %h", BusMuxOut, e);
    else passes++;
    idle();
  endtask

  task automatic test_ops();
    logic [4:0]  ops  [12];
    logic [31:0] want [12];
    ops[0]  = 5'b00011; want[0]  = 32'h8000_00F5;
    ops[1]  = 5'b00100; want[1]  = 32'h8000_00ED;
    ops[2]  = 5'b00101; want[2]  = 32'h0800_000F;
    ops[3]  = 5'b00110; want[3]  = 32'hF800_000F;
    ops[4]  = 5'b00111; want[4]  = 32'h0000_0F10;
    ops[5]  = 5'b01000; want[5]  = 32'h1800_000F;
    ops[6]  = 5'b01001; want[6]  = 32'h0000_0F18;
    ops[7]  = 5'b01010; want[7]  = 32'h0000_0000;
    ops[8]  = 5'b01011; want[8]  = 32'h8000_00F5;
    ops[9]  = 5'b10000; want[9]  = 32'hFFFF_FFFC;
    ops[10] = 5'b10001; want[10] = 32'hFFFF_FFFB;
    ops[11] = 5'b11111; want[11] = 32'h0000_0000;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(want[i]);
      exp_q.push_back(32'h0);
      run_alu(ops[i], 32'h8000_00F1, 32'd4);
      ZLowOut = 1; #1;
      e = exp_q.pop_front();
      checks++;
      if (BusMuxOut !== e)
        $display("FAIL op%b_lo got %h want %h", ops[i], BusMuxOut, e);
      else passes++;
      ZLowOut = 0; ZHighOut = 1; #1;
      e = exp_q.pop_front();
      checks++;
      if (BusMuxOut !== e)
        $display("FAIL op%b_hi got %h want %h", ops[i], BusMuxOut, e);
      else passes++;
      idle();
    end
  endtask

  task automatic test_back_to_back();
    load_reg(0, 32'h11);
    load_reg(5, 32'h55);
    load_mdr(32'h77);
    MDRout = 1; HIin = 1;
    tick();
    load_mdr(32'h99);
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: exp_q.push_back(32'h55);
        1: exp_q.push_back(32'h11);
        2: exp_q.push_back(32'h77);
        default: exp_q.push_back(32'h0);
      endcase
      rout[0] = (s == 1);
      rout[5] = (s < 2);
      HIout   = (s < 3);
      MDRout  = (s < 3);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (BusMuxOut !== e)
        $display("FAIL prio%0d got %h want %h", s, BusMuxOut, e);
      else passes++;
      idle();
    end
    MDRout = 1; MDRin = 1; Read = 1; Mdatain = 32'hAB;
    exp_q.push_back(32'h99);
    exp_q.push_back(32'hAB);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL same_cycle_old got %h want %h", BusMuxOut, e);
    else passes++;
    tick();
    MDRout = 1; Cin = 1; LOin = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL same_cycle_new got %h want %h", BusMuxOut, e);
    else passes++;
    exp_q.push_back(32'hAB);
    exp_q.push_back(32'hAB);
    tick();
    Cout = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL c_reg got %h want %h", BusMuxOut, e);
    else passes++;
    Cout = 0; LOout = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL lo_reg got %h want %h", BusMuxOut, e);
    else passes++;
    idle();
  endtask

  task automatic test_reset_mid();
    load_reg(4, 32'h1234);
    Mdatain = 32'h5555; Read = 1; MDRin = 1;
    #1;
    clr = 0;
    for (int s = 0; s < 3; s++) begin
      exp_q.push_back(32'h0);
      rout[4] = (s == 0);
      MDRout  = (s == 1);
      PCout   = (s == 2);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (BusMuxOut !== e)
        $display("FAIL midrst_src%0d got %h want %h", s, BusMuxOut, e);
      else passes++;
      rout[4] = 0; MDRout = 0; PCout = 0;
    end
    clr = 1;
    idle();
    exp_q.push_back(32'h4321);
    load_reg(4, 32'h4321);
    rout[4] = 1; #1;
    e = exp_q.pop_front();
    checks++;
    if (BusMuxOut !== e)
      $display("FAIL midrst_load got %h want %h", BusMuxOut, e);
    else passes++;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_pc_inc();
    test_mdr();
    test_and();
    test_div();
    test_mul();
    test_ops();
    test_back_to_back();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
